// File: rtl/viterbi_pkg.sv
// Shared constants, types and helpers for the K=7, rate 1/2 hard-decision
// Viterbi decoder and its companion convolutional encoder.
package viterbi_pkg;

  localparam int K           = 7;
  localparam int NUM_STATES  = 64;
  localparam int TB_DEPTH    = 27;
  localparam int METRIC_W    = 8;
  localparam int METRIC_INIT = 32;

  localparam logic [K-1:0] G0 = 7'o171;
  localparam logic [K-1:0] G1 = 7'o133;

  typedef logic [METRIC_W-1:0] metric_t;
  typedef logic [TB_DEPTH-1:0] surv_t;
  typedef logic [K-2:0]        state_t;

  // Even/odd parity of a tapped register vector.
  function automatic logic parity7(input logic [K-1:0] v);
    return ^v;
  endfunction

  // Code pair {G0 bit, G1 bit} emitted when input u enters state st.
  // The generator MSB taps the new input bit.
  function automatic logic [1:0] code_pair(input logic u, input state_t st);
    return {parity7(G0 & {u, st}), parity7(G1 & {u, st})};
  endfunction

  // Hamming distance between two 2-bit pairs (0..2).
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

  // Modulo-wrap "a < b": the sign of the 8-bit difference decides, so the
  // metrics may overflow freely as long as their spread stays below half range.
  function automatic logic metric_lt(input metric_t a, input metric_t b);
    metric_t diff;
    diff = a - b;
    return diff[METRIC_W-1];
  endfunction

endpackage

// File: rtl/viterbi_decoder1_if.sv
// Code-pair stream into the decoder and decoded bit stream out of it.
interface viterbi_decoder1_if;
  logic enb;
  logic in_0;
  logic in_1;
  logic decoded;
  logic decode_valid;

  modport master (
    output enb, in_0, in_1,
    input  decoded, decode_valid
  );

  modport slave (
    input  enb, in_0, in_1,
    output decoded, decode_valid
  );
endinterface

// File: rtl/convolutional_encoder.sv
// Rate 1/2, K=7 convolutional encoder (G0=171, G1=133 octal) with registered
// outputs; one information bit is consumed per enabled edge.
module convolutional_encoder
  import viterbi_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic encode_en,
  input  logic audio_in,
  output logic encoded_out_odd,
  output logic encoded_out_even,
  output logic encode_valid
);

  state_t sr_q, sr_d;
  logic   odd_q, odd_d;
  logic   even_q, even_d;
  logic   valid_q, valid_d;
  logic [1:0] pair;

  // Encode the incoming bit against the current state and advance the state.
  always_comb begin
    sr_d    = sr_q;
    odd_d   = odd_q;
    even_d  = even_q;
    valid_d = valid_q;
    pair    = code_pair(audio_in, sr_q);
    if (encode_en) begin
      odd_d   = pair[1];
      even_d  = pair[0];
      sr_d    = {audio_in, sr_q[K-2:1]};
      valid_d = 1'b1;
    end
  end

  // Encoder state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      odd_q   <= 1'b0;
      even_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      odd_q   <= odd_d;
      even_q  <= even_d;
      valid_q <= valid_d;
    end
  end

  assign encoded_out_odd  = odd_q;
  assign encoded_out_even = even_q;
  assign encode_valid     = valid_q;

endmodule

// File: rtl/viterbi_acs.sv
// Compare-select for one trellis state: takes the two already-added candidate
// metrics and keeps the smaller; ties go to the predecessor ending in 0.
module viterbi_acs
  import viterbi_pkg::*;
(
  input  metric_t cand0_i,
  input  metric_t cand1_i,
  output metric_t metric_o,
  output logic    dec_o
);

  // Take predecessor 1 only when it is strictly better.
  always_comb begin
    dec_o    = metric_lt(cand1_i, cand0_i);
    metric_o = dec_o ? cand1_i : cand0_i;
  end

endmodule

// File: rtl/viterbi_decoder1.sv
// Hard-decision Viterbi decoder for the K=7, rate 1/2 (171,133) code.
// 64 parallel ACS units, 8-bit wrapping path metrics and 27-deep
// register-exchange survivors; one code pair is consumed per enabled edge.
module viterbi_decoder1
  import viterbi_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enb,
  input  logic Viterbi_Decoder1_in_0,
  input  logic Viterbi_Decoder1_in_1,
  output logic decoded,
  output logic decode_valid
);

  metric_t    metric_q [NUM_STATES];
  metric_t    metric_d [NUM_STATES];
  surv_t      surv_q   [NUM_STATES];
  surv_t      surv_d   [NUM_STATES];
  metric_t    cand0    [NUM_STATES];
  metric_t    cand1    [NUM_STATES];
  logic       dec      [NUM_STATES];

  logic [4:0] cnt_q, cnt_d;
  logic       decoded_q, decoded_d;
  logic       valid_q, valid_d;

  logic [1:0] rx_pair;
  state_t     best_idx;
  metric_t    best_metric;

  assign rx_pair = {Viterbi_Decoder1_in_0, Viterbi_Decoder1_in_1};

  // Branch metric add: state s is reached from {s[4:0],b} with input u = s[5].
  always_comb begin
    state_t st;
    state_t p0;
    state_t p1;
    st = '0;
    p0 = '0;
    p1 = '0;
    for (int s = 0; s < NUM_STATES; s++) begin
      st       = state_t'(s);
      p0       = {st[K-3:0], 1'b0};
      p1       = {st[K-3:0], 1'b1};
      cand0[s] = metric_q[p0]
               + {{(METRIC_W-2){1'b0}}, hamming2(rx_pair, code_pair(st[K-2], p0))};
      cand1[s] = metric_q[p1]
               + {{(METRIC_W-2){1'b0}}, hamming2(rx_pair, code_pair(st[K-2], p1))};
    end
  end

  for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
    viterbi_acs u_acs (
      .cand0_i  (cand0[g]),
      .cand1_i  (cand1[g]),
      .metric_o (metric_d[g]),
      .dec_o    (dec[g])
    );
  end

  // Register exchange: inherit the chosen predecessor's survivor, append u.
  always_comb begin
    state_t st;
    state_t pred;
    st   = '0;
    pred = '0;
    for (int s = 0; s < NUM_STATES; s++) begin
      st        = state_t'(s);
      pred      = {st[K-3:0], dec[s]};
      surv_d[s] = {surv_q[pred][TB_DEPTH-2:0], st[K-2]};
    end
  end

  // Best state among the current metrics (lowest index on ties); its oldest
  // survivor bit is the decision, and the valid counter tracks fill depth.
  always_comb begin
    best_metric = metric_q[0];
    best_idx    = '0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (metric_lt(metric_q[s], best_metric)) begin
        best_metric = metric_q[s];
        best_idx    = state_t'(s);
      end
    end
    decoded_d = surv_q[best_idx][TB_DEPTH-1];
    cnt_d     = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
    valid_d   = valid_q | (cnt_q >= 5'(TB_DEPTH - 1));
  end

  // Trellis state, survivors and output registers; everything holds when enb is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        metric_q[s] <= (s == 0) ? '0 : metric_t'(METRIC_INIT);
        surv_q[s]   <= '0;
      end
      cnt_q     <= '0;
      decoded_q <= 1'b0;
      valid_q   <= 1'b0;
    end else if (enb) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        metric_q[s] <= metric_d[s];
        surv_q[s]   <= surv_d[s];
      end
      cnt_q     <= cnt_d;
      decoded_q <= decoded_d;
      valid_q   <= valid_d;
    end
  end

  assign decoded      = decoded_q;
  assign decode_valid = valid_q;

endmodule

// File: tb/tb_viterbi_decoder1.sv
// Directed bench: encoder feeding the Viterbi decoder through the stream
// interface, with a bit-history model for the 28-edge end-to-end delay.
module tb_viterbi_decoder1;

  localparam logic [6:0] TG0 = 7'o171;
  localparam logic [6:0] TG1 = 7'o133;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic audio = 1'b0;
  logic flip0 = 1'b0;
  logic enc_odd, enc_even, enc_valid;

  int errors = 0;
  int checks = 0;
  int k = 0;

  logic       hist [0:1023];
  logic [5:0] msr = '0;
  logic       exp_odd = 1'b0;
  logic       exp_even = 1'b0;
  logic       exp_ev = 1'b0;
  logic       rnd [200];
  logic [1:0] imp_tbl [8];

  viterbi_decoder1_if bus ();

  always #5 clk = ~clk;

  convolutional_encoder u_enc (
    .clk              (clk),
    .reset            (rst),
    .encode_en        (en),
    .audio_in         (audio),
    .encoded_out_odd  (enc_odd),
    .encoded_out_even (enc_even),
    .encode_valid     (enc_valid)
  );

  assign bus.enb  = en;
  assign bus.in_0 = enc_odd ^ flip0;
  assign bus.in_1 = enc_even;

  viterbi_decoder1 dut (
    .clk                   (clk),
    .reset                 (rst),
    .enb                   (bus.enb),
    .Viterbi_Decoder1_in_0 (bus.in_0),
    .Viterbi_Decoder1_in_1 (bus.in_1),
    .decoded               (bus.decoded),
    .decode_valid          (bus.decode_valid)
  );

  function automatic logic exp_dec();
    return (k >= 29) ? hist[k-28] : 1'b0;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s (k=%0d): observed=%b expected=%b", tag, k, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_decoded"}, {1'b0, bus.decoded}, {1'b0, exp_dec()});
    check({tag, "_valid"}, {1'b0, bus.decode_valid}, {1'b0, (k >= 27)});
    check({tag, "_enc_odd"}, {1'b0, enc_odd}, {1'b0, exp_odd});
    check({tag, "_enc_even"}, {1'b0, enc_even}, {1'b0, exp_even});
    check({tag, "_enc_valid"}, {1'b0, enc_valid}, {1'b0, exp_ev});
  endtask

  task automatic step(input logic a, input logic flip, input string tag);
    audio = a;
    en    = 1'b1;
    flip0 = flip;
    @(posedge clk);
    #1;
    flip0    = 1'b0;
    k++;
    hist[k]  = a;
    exp_odd  = ^(TG0 & {a, msr});
    exp_even = ^(TG1 & {a, msr});
    exp_ev   = 1'b1;
    msr      = {a, msr[5:1]};
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    en = 1'b0;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input int edges, input string tag);
    rst = 1'b1;
    repeat (edges) @(posedge clk);
    #1;
    k        = 0;
    msr      = '0;
    exp_odd  = 1'b0;
    exp_even = 1'b0;
    exp_ev   = 1'b0;
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    imp_tbl = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00};
    for (int i = 0; i < 200; i++) rnd[i] = 1'($urandom_range(0, 1));

    // Power-on reset held for two edges.
    en = 1'b0;
    do_reset(2, "reset");

    // All-zero stream; valid rises on the 27th pair.
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, "zeros");
      if (k == 26) check("valid_before_27", {1'b0, bus.decode_valid}, 2'b00);
      if (k == 27) check("valid_at_27", {1'b0, bus.decode_valid}, 2'b01);
    end

    // Impulse: known generator response, then one decoded 1 after 28 edges.
    step(1'b1, 1'b0, "impulse");
    check("impulse_pair0", {enc_odd, enc_even}, imp_tbl[0]);
    for (int j = 1; j < 8; j++) begin
      step(1'b0, 1'b0, "impulse");
      check("impulse_pair", {enc_odd, enc_even}, imp_tbl[j]);
    end
    for (int j = 0; j < 30; j++) step(1'b0, 1'b0, "impulse_tail");

    // Random stream, then reset at pair 100.
    for (int i = 0; i < 100; i++) step(rnd[i], 1'b0, "random_a");
    check("valid_before_midreset", {1'b0, bus.decode_valid}, 2'b01);
    en = 1'b1;
    do_reset(1, "midreset");

    // Restart the same stream with one channel error and a 5-cycle pause.
    for (int i = 0; i < 200; i++) begin
      if (i == 150) begin
        for (int p = 0; p < 5; p++) idle("pause");
      end
      step(rnd[i], (i == 120), "random_b");
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, "flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
